pmt_acq_sequencer: RTL and testbench

Run controller for the PMT timebin counter path. It generates the timebin boundaries, clears the external photon counter at each boundary and captures its 8-bit count. It sequences a run of N bins and hands each captured count to the readout logic over a valid/ready handshake. It sits between the PC-facing control registers and the PMT counter/readout.

---
 rtl/pmt_pkg.sv | 29 ++
 rtl/pmt_bin_timer.sv | 39 +++
 rtl/pmt_acq_sequencer.sv | 170 +++++++++++++++++
 tb/tb_pmt_acq_sequencer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmt_pkg.sv
// ---------------------------------------------------------------------------
// pmt_pkg
// Shared definitions for the PMT acquisition sequencer: default timing
// parameters, sequencer state codes and a small state-decode helper.
// ---------------------------------------------------------------------------
package pmt_pkg;

  localparam int TICKS_PER_UNIT_DEF = 5000;  // 100 us at 50 MHz
  localparam int TIMER_W_DEF        = 22;    // holds 255 * 5000
  localparam int BIN_W_DEF          = 16;

  // Sequencer states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARM   = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // A run is in progress in ARM, RUN and DRAIN
  function automatic logic state_is_busy(input logic [2:0] st);
    logic v_busy;
    case (st)
      ST_ARM, ST_RUN, ST_DRAIN: v_busy = 1'b1;
      default:                  v_busy = 1'b0;
    endcase
    return v_busy;
  endfunction

endpackage

// File: rtl/pmt_bin_timer.sv
// ---------------------------------------------------------------------------
// pmt_bin_timer
// Timebin down-counter. Loads a start value, counts down while enabled and
// flags the boundary cycle (counter at zero while enabled).
//   clk, reset_n : clock, async active-low reset
//   i_load       : load i_load_val on the next edge (has priority)
//   i_load_val   : start value (bin length in cycles minus one)
//   i_en         : count down / report boundaries
//   o_tick       : boundary cycle
// ---------------------------------------------------------------------------
module pmt_bin_timer #(
  parameter int TIMER_W = 22
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_load,
  input  logic [TIMER_W-1:0] i_load_val,
  input  logic               i_en,
  output logic               o_tick
);

  logic [TIMER_W-1:0] r_timer;

  // Down-counter; a reload on the boundary cycle keeps the bin period exact
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer <= {TIMER_W{1'b0}};
    end else if (i_load) begin
      r_timer <= i_load_val;
    end else if (i_en) begin
      r_timer <= r_timer - {{(TIMER_W-1){1'b0}}, 1'b1};
    end else begin
      r_timer <= r_timer;
    end
  end

  assign o_tick = i_en && (r_timer == {TIMER_W{1'b0}});

endmodule

// File: rtl/pmt_acq_sequencer.sv
// ---------------------------------------------------------------------------
// pmt_acq_sequencer
// Run controller for the PMT timebin counter path. Generates bin boundaries,
// clears the external photon counter at each boundary, captures its count
// and hands each count to the readout over valid/ready.
//   clk, reset_n   : clock, async active-low reset
//   start, abort   : one-cycle run request / cancel (abort wins)
//   bin_factor     : bin length in units, latched at start (0 is rejected)
//   num_bins       : bins per run, latched at start (0 = free-run)
//   count_in       : live PMT count
//   counter_clear  : clear pulse to the PMT counter (ARM and each boundary)
//   data_out/_valid/_ready : captured count handshake
//   bin_index      : 1-based index of the last captured bin
//   busy, done     : run in progress / normal end pulse
//   overrun        : sticky, unread bin overwritten
//   cfg_err        : sticky, start rejected for bin_factor == 0
//   led            : toggles at every bin boundary
// ---------------------------------------------------------------------------
module pmt_acq_sequencer
  import pmt_pkg::*;
#(
  parameter int TICKS_PER_UNIT = TICKS_PER_UNIT_DEF,
  parameter int TIMER_W        = TIMER_W_DEF,
  parameter int BIN_W          = BIN_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       bin_factor,
  input  logic [BIN_W-1:0] num_bins,
  input  logic [7:0]       count_in,
  output logic             counter_clear,
  output logic [7:0]       data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic [BIN_W-1:0] bin_index,
  output logic             busy,
  output logic             done,
  output logic             overrun,
  output logic             cfg_err,
  output logic             led
);

  logic [2:0]         r_state;
  logic [7:0]         r_bin_factor;
  logic [BIN_W-1:0]   r_num_bins;
  logic [7:0]         r_data_out;
  logic               r_data_valid;
  logic [BIN_W-1:0]   r_bin_index;
  logic               r_overrun;
  logic               r_cfg_err;
  logic               r_led;

  logic               w_tick;
  logic               w_timer_load;
  logic               w_timer_en;
  logic [TIMER_W-1:0] w_load_val;
  logic               w_xfer;
  logic               w_capture;
  logic               w_last_bin;

  // Handshake, boundary and timer-control decode
  always_comb begin
    w_xfer       = r_data_valid && data_ready;
    w_timer_en   = (r_state == ST_RUN);
    w_capture    = w_tick && !abort;
    w_timer_load = (r_state == ST_ARM) || w_tick;
    // Full-width product: bin_factor * TICKS_PER_UNIT - 1, never truncated
    w_load_val   = ({{(TIMER_W-8){1'b0}}, r_bin_factor} * TIMER_W'(TICKS_PER_UNIT))
                   - {{(TIMER_W-1){1'b0}}, 1'b1};
    w_last_bin   = (r_num_bins != {BIN_W{1'b0}}) &&
                   ((r_bin_index + {{(BIN_W-1){1'b0}}, 1'b1}) == r_num_bins);
  end

  pmt_bin_timer #(
    .TIMER_W (TIMER_W)
  ) u_bin_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_timer_load),
    .i_load_val (w_load_val),
    .i_en       (w_timer_en),
    .o_tick     (w_tick)
  );

  // Sequencer state, capture register and handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_bin_factor <= 8'd0;
      r_num_bins   <= {BIN_W{1'b0}};
      r_data_out   <= 8'd0;
      r_data_valid <= 1'b0;
      r_bin_index  <= {BIN_W{1'b0}};
      r_overrun    <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_led        <= 1'b0;
    end else begin
      // Capture beats accept: a same-cycle accept consumes the old bin, so
      // valid stays up and only an unaccepted old bin counts as overrun.
      if (abort && (r_state != ST_IDLE)) begin
        r_data_valid <= 1'b0;
      end else if (w_capture) begin
        r_data_out   <= count_in;
        r_data_valid <= 1'b1;
        r_bin_index  <= r_bin_index + {{(BIN_W-1){1'b0}}, 1'b1};
        r_led        <= ~r_led;
        if (r_data_valid && !data_ready) begin
          r_overrun <= 1'b1;
        end
      end else if (w_xfer) begin
        r_data_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            if (bin_factor != 8'd0) begin
              r_bin_factor <= bin_factor;
              r_num_bins   <= num_bins;
              r_overrun    <= 1'b0;
              r_cfg_err    <= 1'b0;
              r_bin_index  <= {BIN_W{1'b0}};
              r_state      <= ST_ARM;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        ST_ARM: begin
          r_state <= abort ? ST_IDLE : ST_RUN;
        end
        ST_RUN: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else if (w_capture && w_last_bin) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else if (!r_data_valid || w_xfer) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Clear is issued in ARM and on the boundary cycle itself, so clear pulses
  // are exactly one bin period apart.
  assign counter_clear = (r_state == ST_ARM) || w_tick;
  assign data_out      = r_data_out;
  assign data_valid    = r_data_valid;
  assign bin_index     = r_bin_index;
  assign busy          = state_is_busy(r_state);
  assign done          = (r_state == ST_DONE);
  assign overrun       = r_overrun;
  assign cfg_err       = r_cfg_err;
  assign led           = r_led;

endmodule

// File: tb/tb_pmt_acq_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pmt_acq_sequencer
// Self-checking bench for pmt_acq_sequencer with TICKS_PER_UNIT = 4.
// ---------------------------------------------------------------------------
module tb_pmt_acq_sequencer;

  localparam int TPU = 4;
  localparam int BW  = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [7:0]    bin_factor = 8'd0;
  logic [BW-1:0] num_bins = 16'd0;
  logic [7:0]    count_in = 8'd0;
  logic          data_ready = 1'b0;
  logic          counter_clear;
  logic [7:0]    data_out;
  logic          data_valid;
  logic [BW-1:0] bin_index;
  logic          busy;
  logic          done;
  logic          overrun;
  logic          cfg_err;
  logic          led;

  int n_cmp = 0;
  int n_err = 0;

  // reference model of the readout-visible state
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ovr;
  int         m_idx;
  logic       m_led;

  typedef struct {
    logic        st;
    logic        ab;
    logic [7:0]  bf;
    logic [15:0] nb;
    logic        e_busy;
    logic        e_cfg;
    logic        e_clr;
    logic        e_done;
  } vec_t;

  vec_t tbl[14];

  always #5 clk = ~clk;

  pmt_acq_sequencer #(
    .TICKS_PER_UNIT (TPU),
    .TIMER_W        (22),
    .BIN_W          (BW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .abort         (abort),
    .bin_factor    (bin_factor),
    .num_bins      (num_bins),
    .count_in      (count_in),
    .counter_clear (counter_clear),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .bin_index     (bin_index),
    .busy          (busy),
    .done          (done),
    .overrun       (overrun),
    .cfg_err       (cfg_err),
    .led           (led)
  );

  function automatic vec_t mk(input logic st, input logic ab, input logic [7:0] bf,
                              input logic [15:0] nb, input logic eb, input logic ec,
                              input logic el, input logic ed);
    vec_t v;
    v.st = st; v.ab = ab; v.bf = bf; v.nb = nb;
    v.e_busy = eb; v.e_cfg = ec; v.e_clr = el; v.e_done = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string p);
    chk({p, "_clr"},  32'(counter_clear), 32'd0);
    chk({p, "_data"}, 32'(data_out),      32'd0);
    chk({p, "_vld"},  32'(data_valid),    32'd0);
    chk({p, "_idx"},  32'(bin_index),     32'd0);
    chk({p, "_busy"}, 32'(busy),          32'd0);
    chk({p, "_done"}, 32'(done),          32'd0);
    chk({p, "_ovr"},  32'(overrun),       32'd0);
    chk({p, "_cfg"},  32'(cfg_err),       32'd0);
    chk({p, "_led"},  32'(led),           32'd0);
  endtask

  // One run under random ready/count, checked every cycle against a
  // timeline model: clears at c=0 and every P cycles, captures on boundaries.
  task automatic rand_run(input int bf, input int nb);
    int P, c, phase, guard;
    logic rdy, cap, was_valid, ab_now;
    logic [7:0] cnt;
    P = bf * TPU;
    bin_factor = 8'(bf);
    num_bins   = 16'(nb);
    rdy = 1'($urandom_range(0, 1));
    data_ready = rdy;
    count_in = 8'($urandom);
    start = 1'b1;
    if (m_valid && rdy) m_valid = 1'b0;
    m_ovr = 1'b0;
    m_idx = 0;
    step();
    start = 1'b0;
    c = 0; phase = 1; guard = 0;
    while (phase != 0 && guard < 3000) begin
      chk("F_clr",  32'(counter_clear), 32'((phase == 1) && (c == 0 || (c % P) == 0)));
      chk("F_busy", 32'(busy),          32'(phase == 1 || phase == 2));
      chk("F_done", 32'(done),          32'(phase == 3));
      chk("F_vld",  32'(data_valid),    32'(m_valid));
      chk("F_data", 32'(data_out),      32'(m_data));
      chk("F_idx",  32'(bin_index),     32'(16'(m_idx)));
      chk("F_ovr",  32'(overrun),       32'(m_ovr));
      chk("F_led",  32'(led),           32'(m_led));
      rdy = 1'($urandom_range(0, 1));
      cnt = 8'($urandom);
      data_ready = rdy;
      count_in = cnt;
      ab_now = (nb == 0) && (phase == 1) && (c == 3 * P + 1);
      abort = ab_now;
      cap = (phase == 1) && (c > 0) && ((c % P) == 0);
      was_valid = m_valid;
      if (ab_now) begin
        m_valid = 1'b0;
        phase = 0;
      end else begin
        if (cap) begin
          if (m_valid && !rdy) m_ovr = 1'b1;
          m_valid = 1'b1;
          m_data = cnt;
          m_idx++;
          m_led = ~m_led;
        end else if (m_valid && rdy) begin
          m_valid = 1'b0;
        end
        case (phase)
          1: if (cap && nb != 0 && m_idx == nb) phase = 2; else c++;
          2: if (!was_valid || rdy) phase = 3;
          default: phase = 0;
        endcase
      end
      step();
      abort = 1'b0;
      guard++;
    end
    chk("F_timeout", 32'(guard < 3000), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("F_idle_busy", 32'(busy),          32'd0);
      chk("F_idle_clr",  32'(counter_clear), 32'd0);
      chk("F_idle_vld",  32'(data_valid),    32'(m_valid));
      chk("F_idle_idx",  32'(bin_index),     32'(16'(m_idx)));
      rdy = 1'($urandom_range(0, 1));
      data_ready = rdy;
      if (m_valid && rdy) m_valid = 1'b0;
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int clr_q[$];
    int cap_i[$];
    logic [7:0] cap_d[$];
    int done_cnt, done_cyc;
    logic prev_valid, bad;
    logic [7:0] exp_d[2];
    int exp_c[3];

    // ---------------- reset state ----------------
    #2;
    chk_all_zero("R0");
    step(); step();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk_all_zero("R1");

    // ---------------- table-driven control vectors ----------------
    tbl[0]  = mk(1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 1'b0, 8'd0, 16'd2, 1'b0, 1'b1, 1'b0, 1'b0); // rejected start
    tbl[2]  = mk(1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0); // cfg_err sticky
    tbl[3]  = mk(1'b1, 1'b0, 8'd1, 16'd1, 1'b1, 1'b0, 1'b1, 1'b0); // ARM
    tbl[4]  = mk(1'b0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0); // config ignored now
    tbl[5]  = mk(1'b0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[6]  = mk(1'b0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0, 1'b1, 1'b0); // boundary
    tbl[8]  = mk(1'b0, 1'b0, 8'd0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0); // DRAIN
    tbl[9]  = mk(1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1); // DONE
    tbl[10] = mk(1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[11] = mk(1'b1, 1'b1, 8'd2, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0); // abort beats start
    tbl[12] = mk(1'b1, 1'b0, 8'd2, 16'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    tbl[13] = mk(1'b0, 1'b1, 8'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0); // abort in ARM
    data_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      start = tbl[i].st;
      abort = tbl[i].ab;
      bin_factor = tbl[i].bf;
      num_bins = tbl[i].nb;
      count_in = 8'h00;
      step();
      chk($sformatf("T%0d_busy", i), 32'(busy),          32'(tbl[i].e_busy));
      chk($sformatf("T%0d_cfg", i),  32'(cfg_err),       32'(tbl[i].e_cfg));
      chk($sformatf("T%0d_clr", i),  32'(counter_clear), 32'(tbl[i].e_clr));
      chk($sformatf("T%0d_done", i), 32'(done),          32'(tbl[i].e_done));
    end
    start = 1'b0;
    abort = 1'b0;

    // ---------------- A: basic two-bin run ----------------
    bin_factor = 8'd3; num_bins = 16'd2; data_ready = 1'b1; count_in = 8'h15;
    start = 1'b1;
    step();
    start = 1'b0;
    prev_valid = 1'b0; done_cnt = 0; done_cyc = -1;
    for (int k = 1; k <= 40; k++) begin
      if (counter_clear) clr_q.push_back(k);
      if (data_valid && !prev_valid) begin
        cap_d.push_back(data_out);
        cap_i.push_back(int'(bin_index));
      end
      prev_valid = data_valid;
      if (done) begin done_cnt++; done_cyc = k; end
      if (k == 14) count_in = 8'h2A;
      step();
    end
    exp_c[0] = 1; exp_c[1] = 13; exp_c[2] = 25;
    exp_d[0] = 8'h15; exp_d[1] = 8'h2A;
    chk("A_clr_count", 32'(clr_q.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("A_clr%0d_cycle", i), 32'((i < clr_q.size()) ? clr_q[i] : -1), 32'(exp_c[i]));
    chk("A_cap_count", 32'(cap_d.size()), 32'd2);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("A_data%0d", i), 32'((i < cap_d.size()) ? cap_d[i] : 8'hFF), 32'(exp_d[i]));
      chk($sformatf("A_idx%0d", i),  32'((i < cap_i.size()) ? cap_i[i] : -1),    32'(i + 1));
    end
    chk("A_done_cnt", 32'(done_cnt), 32'd1);
    chk("A_done_cyc", 32'(done_cyc), 32'd27);
    chk("A_busy_end", 32'(busy), 32'd0);

    // ---------------- B: overrun and DRAIN hold ----------------
    bin_factor = 8'd1; num_bins = 16'd3; data_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      count_in = 8'h30 + 8'(k);
      if (k == 9)  chk("B_ovr_bin1", 32'(overrun), 32'd0);
      if (k == 10) chk("B_ovr_bin2", 32'(overrun), 32'd1);
      step();
    end
    bad = 1'b0;
    for (int k = 14; k <= 18; k++) begin
      if (!busy || done || !data_valid) bad = 1'b1;
      step();
    end
    chk("B_drain_hold", 32'(bad), 32'd0);
    chk("B_data", 32'(data_out), 32'h3D);
    chk("B_idx",  32'(bin_index), 32'd3);
    chk("B_ovr",  32'(overrun), 32'd1);
    data_ready = 1'b1;
    step();
    chk("B_done", 32'(done), 32'd1);
    chk("B_vld",  32'(data_valid), 32'd0);
    data_ready = 1'b0;
    step();
    chk("B_idle", 32'(busy), 32'd0);

    // ---------------- C: capture and accept on the same cycle ----------------
    bin_factor = 8'd1; num_bins = 16'd2; data_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      count_in = 8'h50 + 8'(k);
      if (k == 9) begin
        chk("C_vld_before", 32'(data_valid), 32'd1);
        data_ready = 1'b1;
      end
      step();
    end
    chk("C_vld",  32'(data_valid), 32'd1);
    chk("C_ovr",  32'(overrun), 32'd0);
    chk("C_data", 32'(data_out), 32'h59);
    chk("C_idx",  32'(bin_index), 32'd2);
    step();
    chk("C_done", 32'(done), 32'd1);
    data_ready = 1'b0;
    step();

    // ---------------- D: abort during RUN, then clean restart ----------------
    bin_factor = 8'd1; num_bins = 16'd4; data_ready = 1'b0; count_in = 8'h77;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k < 6; k++) step();
    chk("D_idx_bin1", 32'(bin_index), 32'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("D_busy", 32'(busy), 32'd0);
    chk("D_vld",  32'(data_valid), 32'd0);
    chk("D_idx_hold", 32'(bin_index), 32'd1);
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (done || busy || counter_clear) bad = 1'b1;
      step();
    end
    chk("D_no_done", 32'(bad), 32'd0);
    num_bins = 16'd1; data_ready = 1'b1; count_in = 8'h0C;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k < 6; k++) step();
    chk("D2_idx",  32'(bin_index), 32'd1);
    chk("D2_data", 32'(data_out), 32'h0C);
    step();
    chk("D2_done", 32'(done), 32'd1);
    data_ready = 1'b0;
    step();

    // ---------------- E: asynchronous reset mid-RUN ----------------
    bin_factor = 8'd2; num_bins = 16'd4; data_ready = 1'b0; count_in = 8'hA5;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k < 10; k++) step();
    chk("E_vld_pre", 32'(data_valid), 32'd1);
    chk("E_idx_pre", 32'(bin_index), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("E_rst");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (busy || counter_clear || data_valid || done) bad = 1'b1;
    end
    chk("E_idle_after", 32'(bad), 32'd0);

    // ---------------- F: randomized runs against the model ----------------
    m_valid = 1'b0; m_data = 8'd0; m_ovr = 1'b0; m_idx = 0; m_led = 1'b0;
    for (int r = 0; r < 8; r++) begin
      rand_run($urandom_range(1, 3), (r == 7) ? 0 : $urandom_range(1, 4));
    end
    chk("F_cfg", 32'(cfg_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
